// File: rtl/done_hdr.sv
// Completion handler: arms on a PE start edge, gathers sticky per-PE done bits,
// raises ap_done on all-done or watchdog expiry, and keeps run statistics.
module done_hdr #(
    parameter int unsigned NUM_PE = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned TO_W   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sys_start,
    input  logic              pe_start,
    input  logic [NUM_PE-1:0] pe_done,
    input  logic              ap_continue,
    input  logic [TO_W-1:0]   timeout_lim,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              busy,
    output logic              timeout,
    output logic [NUM_PE-1:0] done_mask,
    output logic [CNT_W-1:0]  done_cnt,
    output logic [CNT_W-1:0]  run_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    logic              sys_start_r;
    logic              pe_start_r;
    logic [CNT_W-1:0]  cyc;

    logic              ss_pulse;
    logic              ps_edge;
    logic              all_done;
    logic [CNT_W-1:0]  n;
    logic [TO_W-1:0]   n_to;
    logic              wd_hit;

    always_comb begin
        ss_pulse = sys_start & ~sys_start_r;
        ps_edge  = pe_start & ~pe_start_r;
        all_done = &(done_mask | pe_done);
        n        = (cyc == '1) ? cyc : cyc + 1'b1;
        // Truncates or zero-extends the run length to the watchdog width.
        n_to     = TO_W'(n);
        wd_hit   = (timeout_lim != '0) && (n_to == timeout_lim);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            sys_start_r <= 1'b0;
            pe_start_r  <= 1'b0;
            done_mask   <= '0;
            done_cnt    <= '0;
            run_cycles  <= '0;
            timeout     <= 1'b0;
            cyc         <= '0;
        end else begin
            sys_start_r <= sys_start;
            pe_start_r  <= pe_start;
            if (ss_pulse) begin
                state      <= IDLE;
                done_mask  <= '0;
                done_cnt   <= '0;
                run_cycles <= '0;
                timeout    <= 1'b0;
                cyc        <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (ps_edge) begin
                            state     <= RUN;
                            done_mask <= '0;
                            cyc       <= '0;
                        end
                    end
                    RUN: begin
                        done_mask <= done_mask | pe_done;
                        cyc       <= n;
                        // Completion takes precedence over a same-cycle watchdog hit.
                        if (all_done) begin
                            state      <= HOLD;
                            done_cnt   <= done_cnt + 1'b1;
                            run_cycles <= n;
                        end else if (wd_hit) begin
                            state      <= HOLD;
                            timeout    <= 1'b1;
                            run_cycles <= n;
                        end
                    end
                    HOLD: begin
                        if (ap_continue) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ap_idle = (state == IDLE);
    assign busy    = (state == RUN);
    assign ap_done = (state == HOLD);

endmodule

// File: tb/tb_done_hdr.sv
// Directed self-checking bench for done_hdr with hand-computed expectations.
module tb_done_hdr;

    localparam int unsigned NUM_PE = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned TO_W   = 24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sys_start;
    logic              pe_start;
    logic [NUM_PE-1:0] pe_done;
    logic              ap_continue;
    logic [TO_W-1:0]   timeout_lim;
    logic              ap_done;
    logic              ap_idle;
    logic              busy;
    logic              timeout;
    logic [NUM_PE-1:0] done_mask;
    logic [CNT_W-1:0]  done_cnt;
    logic [CNT_W-1:0]  run_cycles;

    int errors = 0;
    int checks = 0;

    done_hdr #(.NUM_PE(NUM_PE), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sys_start   (sys_start),
        .pe_start    (pe_start),
        .pe_done     (pe_done),
        .ap_continue (ap_continue),
        .timeout_lim (timeout_lim),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .busy        (busy),
        .timeout     (timeout),
        .done_mask   (done_mask),
        .done_cnt    (done_cnt),
        .run_cycles  (run_cycles)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic e_idle, input logic e_busy,
                              input logic e_done, input logic e_to, input logic [3:0] e_mask,
                              input int e_cnt, input int e_rc);
        chk({tag, ".ap_idle"},    64'(ap_idle),    64'(e_idle));
        chk({tag, ".busy"},       64'(busy),       64'(e_busy));
        chk({tag, ".ap_done"},    64'(ap_done),    64'(e_done));
        chk({tag, ".timeout"},    64'(timeout),    64'(e_to));
        chk({tag, ".done_mask"},  64'(done_mask),  64'(e_mask));
        chk({tag, ".done_cnt"},   64'(done_cnt),   64'(e_cnt));
        chk({tag, ".run_cycles"}, 64'(run_cycles), 64'(e_rc));
    endtask

    initial begin
        rst_n = 1'b0; sys_start = 1'b0; pe_start = 1'b0; pe_done = '0;
        ap_continue = 1'b1; timeout_lim = '0;
        step(); step();
        chk_status("reset", 1, 0, 0, 0, 4'h0, 0, 0);
        rst_n = 1'b1;
        step();

        // Basic run: edge at A, PE done pulses at A+3, A+5 (two PEs), A+8.
        pe_start = 1'b1; step();              // A+1
        chk("basic.busy_first", 64'(busy), 64'd1);
        pe_start = 1'b0; step(); step();      // A+3
        pe_done = 4'b0001; step();            // A+4
        pe_done = '0;
        chk("basic.mask_a4", 64'(done_mask), 64'h1);
        step();                               // A+5
        pe_done = 4'b0110; step();            // A+6
        pe_done = '0;
        chk("basic.mask_a6", 64'(done_mask), 64'h7);
        chk("basic.busy_a6", 64'(busy), 64'd1);
        step(); step();                       // A+8
        chk("basic.busy_last", 64'(busy), 64'd1);
        pe_done = 4'b1000; step();            // A+9
        pe_done = '0;
        chk_status("basic.hold", 0, 0, 1, 0, 4'hF, 1, 8);
        step();                               // A+10
        chk_status("basic.idle", 1, 0, 0, 0, 4'hF, 1, 8);

        // Held handshake: ap_continue low, re-edge on pe_start during HOLD is ignored.
        ap_continue = 1'b0;
        pe_start = 1'b1; step();              // A+1
        pe_start = 1'b0; step(); step();
        pe_done = 4'b0001; step();
        pe_done = '0; step();
        pe_done = 4'b0110; step();
        pe_done = '0; step(); step();
        pe_done = 4'b1000; step();            // A+9
        pe_done = '0;
        chk_status("held.hold", 0, 0, 1, 0, 4'hF, 2, 8);
        step(); step(); step();               // A+12
        pe_start = 1'b1; step();              // A+13
        pe_start = 1'b0;
        chk("held.ignore_edge", 64'(ap_done), 64'd1);
        step();                               // A+14
        ap_continue = 1'b1; step();           // A+15: acknowledged during A+14
        chk_status("held.idle", 1, 0, 0, 0, 4'hF, 2, 8);
        step();
        chk("held.no_rearm", 64'(ap_idle), 64'd1);

        // Tie: timeout_lim=3 and last done in RUN cycle 3; completion wins.
        timeout_lim = 24'd3;
        pe_start = 1'b1; step();              // RUN cycle 1
        pe_start = 1'b0;
        pe_done = 4'b0011; step();            // RUN cycle 2
        pe_done = '0; step();                 // RUN cycle 3
        chk("tie.busy_c3", 64'(busy), 64'd1);
        pe_done = 4'b1100; step();
        pe_done = '0;
        chk_status("tie.hold", 0, 0, 1, 0, 4'hF, 3, 3);
        step();

        // Watchdog: limit 5, PE3 never reports; PEs 0-2 pulse in RUN cycle 2.
        timeout_lim = 24'd5;
        pe_start = 1'b1; step();              // RUN cycle 1
        pe_start = 1'b0; step();              // RUN cycle 2
        pe_done = 4'b0111; step();            // RUN cycle 3
        pe_done = '0; step(); step();         // RUN cycle 5
        chk("wd.busy_c5", 64'(busy), 64'd1);
        step();
        chk_status("wd.hold", 0, 0, 1, 1, 4'h7, 3, 5);
        step();
        chk("wd.idle", 64'(ap_idle), 64'd1);

        // Minimum run afterwards: timeout stays sticky.
        pe_start = 1'b1; step();              // RUN cycle 1
        pe_start = 1'b0;
        pe_done = 4'hF; step();
        pe_done = '0;
        chk_status("min.hold", 0, 0, 1, 1, 4'hF, 4, 1);
        step();

        // sys_start edge mid-RUN together with a pe_start edge.
        timeout_lim = '0;
        pe_start = 1'b1; step();              // RUN cycle 1
        pe_start = 1'b0;
        pe_done = 4'b0001; step();            // RUN cycle 2
        pe_done = '0;
        chk("ss.mask_before", 64'(done_mask), 64'h1);
        sys_start = 1'b1; pe_start = 1'b1; step();
        chk_status("ss.cleared", 1, 0, 0, 0, 4'h0, 0, 0);
        step();
        chk("ss.no_arm", 64'(ap_idle), 64'd1);
        sys_start = 1'b0; pe_start = 1'b0;
        step();

        // Reset during HOLD with sys_start held high across reset.
        ap_continue = 1'b0;
        pe_start = 1'b1; step();
        pe_start = 1'b0;
        pe_done = 4'hF; step();
        pe_done = '0;
        chk_status("rst.pre_hold", 0, 0, 1, 0, 4'hF, 1, 1);
        rst_n = 1'b0; sys_start = 1'b1; step();
        chk_status("rst.cleared", 1, 0, 0, 0, 4'h0, 0, 0);
        rst_n = 1'b1; step();                 // ss_pulse consumed here
        chk("rst.idle_after_ss", 64'(ap_idle), 64'd1);
        ap_continue = 1'b1; pe_done = 4'hF;
        pe_start = 1'b1; step();
        chk("rst.busy", 64'(busy), 64'd1);
        step();
        chk_status("rst.run_counted", 0, 0, 1, 0, 4'hF, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/done_hdr.md
# done_hdr

Completion-side counterpart to the PE start handler. It arms on a PE start edge and collects per-PE done indications from NUM_PE engines into a sticky mask. When every engine has finished, or a watchdog expires, it raises an ap_done handshake toward the host-side controller and holds it until acknowledged. It also keeps run statistics (completed-run count, last-run cycle count) that a system start clears.

## Interface
Parameters:
- NUM_PE, 4, number of processing engines reporting done (1..32)
- CNT_W, 32, width of done_cnt and run_cycles
- TO_W, 24, width of watchdog limit

Ports:
- clk  input  1  single clock; all logic is on the rising edge
- rst_n  input  1  synchronous, active-low reset
- sys_start  input  1  level signal; its rising edge clears statistics and aborts the current run
- pe_start  input  1  PE start level; its rising edge arms a run
- pe_done  input  NUM_PE  per-PE done; may be a pulse or a level; sampled only in RUN
- ap_continue  input  1  host acknowledge of ap_done
- timeout_lim  input  TO_W  watchdog limit in RUN cycles; 0 disables the watchdog
- ap_done  output  1  high in HOLD
- ap_idle  output  1  high in IDLE
- busy  output  1  high in RUN
- timeout  output  1  sticky watchdog error flag
- done_mask  output  NUM_PE  sticky per-PE completion bits for the current or last run
- done_cnt  output  CNT_W  number of runs that completed normally
- run_cycles  output  CNT_W  RUN-cycle count of the last finished run (completed or timed out)

## Operation
Edge detection:
- Registered copies sys_start_r and pe_start_r reset to 0.
- ss_pulse = sys_start & !sys_start_r.
- ps_edge = pe_start & !pe_start_r.
- If sys_start is held high through reset, ss_pulse fires on the first cycle after reset. This is intended.

Priority, highest first: rst_n low, then ss_pulse, then FSM.

rst_n low: state=IDLE; done_mask=0; done_cnt=0; run_cycles=0; timeout=0; cyc=0; edge registers=0.

ss_pulse: state=IDLE; done_mask=0; done_cnt=0; run_cycles=0; timeout=0; cyc=0. A ps_edge in the same cycle is ignored.

FSM states (IDLE, RUN, HOLD):
- IDLE: ap_idle=1. On ps_edge, go to RUN and set done_mask=0, cyc=0. The timeout flag is not cleared here.
- RUN: busy=1.
  - Each cycle: done_mask <= done_mask | pe_done.
  - cyc <= cyc+1, saturating at all-ones.
  - Define all_done = &(done_mask | pe_done) and n = cyc+1, saturating.
  - If all_done: go to HOLD, done_cnt <= done_cnt+1 (wraps modulo 2^CNT_W), run_cycles <= n.
  - Else if timeout_lim != 0 and n[TO_W-1:0] zero-extended equals timeout_lim: go to HOLD, timeout <= 1, run_cycles <= n. done_cnt is unchanged.
  - Completion beats timeout when both occur in the same cycle.
- HOLD: ap_done=1. On ap_continue=1, go to IDLE. pe_done is ignored and done_mask is frozen.

Ignored inputs:
- ps_edge in RUN or HOLD (no re-arm, no queueing).
- pe_done in IDLE or HOLD.
- ap_continue outside HOLD.

Outputs are decoded directly from the registered state and registers, with no extra register stage. The timeout flag clears only on reset or ss_pulse.

## Timing
- Reset values: ap_idle=1; ap_done=0; busy=0; timeout=0; done_mask=0; done_cnt=0; run_cycles=0.
- ps_edge sampled in cycle N gives busy=1 in cycle N+1.
- all_done true in RUN cycle M gives ap_done=1 in M+1, with done_cnt and run_cycles updated in M+1.
- Minimum run: pe_done all ones in the first RUN cycle. ap_done rises 2 cycles after the ps_edge cycle, and run_cycles=1.
- ap_continue already high when ap_done rises gives a 1-cycle ap_done; ap_idle=1 on the next cycle.
- Earliest re-arm: ps_edge is accepted in the first IDLE cycle after HOLD. pe_start must drop and rise again to produce a new edge.
- Watchdog with timeout_lim=L: a stuck run spends exactly L cycles in RUN. ap_done and timeout rise on the following cycle, with run_cycles=L.
- Single-cycle pe_done pulses from different PEs at different cycles accumulate into done_mask; no pulse is lost.

## Test plan
- Basic run, NUM_PE=4, timeout_lim=0: pe_start rises at cycle 10; PEs pulse done at 13, 15, 15, 18; ap_continue tied high. Required: busy cycles 11-18, ap_done=1 only at cycle 19, done_cnt=1, run_cycles=8, done_mask=4'hF.
- Held handshake: same run with ap_continue low until cycle 25. Required: ap_done high cycles 19-25, ap_idle=1 at 26. A pe_start re-edge at 22 is ignored (done_cnt stays 1).
- Watchdog: timeout_lim=5, PE3 never done, other PEs done at cycle 12. Required: 5 busy cycles, then ap_done with timeout=1, run_cycles=5, done_mask=4'h7, done_cnt unchanged. A following normal run leaves timeout=1.
- Tie: timeout_lim=3 with the last done arriving in RUN cycle 3. Required: done_cnt increments and timeout stays 0.
- sys_start rising edge mid-RUN (3 runs counted so far). Required: next cycle ap_idle=1, done_cnt=0, run_cycles=0, done_mask=0, timeout=0. A simultaneous pe_start edge does not arm a run.
- rst_n low for 1 cycle during HOLD. Required: all outputs return to reset values on the next cycle; sys_start held high through reset clears statistics once.
